// File: rtl/wb_seq_regs_if.sv
// Wishbone classic bus bundle between the management SoC initiator and the
// sequencer register block.
interface wb_seq_regs_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_seq_regs.sv
// Wishbone classic responder holding the motor sequencer control/status
// registers and the sequence memory, with a private registered read port
// for the sequencer core.
module wb_seq_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter int unsigned SEQ_DEPTH = 16,
  parameter logic [31:0] ID_VALUE  = 32'h4D4D_5301
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  wb_seq_regs_if.slave wb,
  output logic         ctrl_enable_o,
  output logic         ctrl_loop_o,
  output logic         start_o,
  output logic [31:0]  step_period_o,
  output logic [3:0]   seq_last_o,
  input  logic [3:0]   seq_rd_addr_i,
  output logic [31:0]  seq_rd_data_o,
  input  logic         seq_busy_i,
  input  logic [3:0]   seq_index_i,
  input  logic         seq_done_i,
  output logic         irq_o
);

  localparam logic [5:0]  OffCtrl   = 6'h00;
  localparam logic [5:0]  OffStatus = 6'h01;
  localparam logic [5:0]  OffPeriod = 6'h02;
  localparam logic [5:0]  OffLast   = 6'h03;
  localparam logic [5:0]  OffId     = 6'h04;
  localparam logic [31:0] PeriodRst = 32'd1000;

  // Bus response
  logic        r_ack;
  logic [31:0] r_dat;
  // Control / status state
  logic        r_enable;
  logic        r_loop;
  logic        r_irq_en;
  logic        r_start;
  logic        r_done;
  logic        r_irq;
  logic [31:0] r_period;
  logic [3:0]  r_last;
  logic [31:0] r_seq [SEQ_DEPTH];
  logic [31:0] r_seq_rd;

  logic        w_hit;
  logic        w_req;
  logic        w_wr;
  logic [5:0]  w_off;
  logic [3:0]  w_seq_idx;
  logic        w_seq_sel;
  logic [31:0] w_rdata;

  // Merge write data into an old word, one byte lane per select bit.
  function automatic logic [31:0] f_lanes(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign w_hit     = (wb.wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  // The ack cycle itself is never a request, so a held strobe is served every other cycle.
  assign w_req     = wb.wbs_cyc_i & wb.wbs_stb_i & w_hit & ~r_ack;
  assign w_wr      = w_req & wb.wbs_we_i;
  assign w_off     = wb.wbs_adr_i[7:2];
  assign w_seq_idx = wb.wbs_adr_i[5:2];
  assign w_seq_sel = (w_off[5:4] == 2'b01) && (32'(w_seq_idx) < SEQ_DEPTH);

  // Read data mux; unmapped offsets and unused bits read as zero.
  always_comb begin
    w_rdata = '0;
    if (w_seq_sel) begin
      w_rdata = r_seq[w_seq_idx];
    end else begin
      case (w_off)
        OffCtrl:   w_rdata = {28'd0, r_irq_en, 1'b0, r_loop, r_enable};
        OffStatus: w_rdata = {23'd0, r_done, seq_index_i, 3'd0, seq_busy_i};
        OffPeriod: w_rdata = r_period;
        OffLast:   w_rdata = {28'd0, r_last};
        OffId:     w_rdata = ID_VALUE;
        default:   w_rdata = '0;
      endcase
    end
  end

  // Single-cycle ack and registered read data, zero outside the ack cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : '0;
    end
  end

  // CTRL register and start pulse; start is self-clearing and ignores busy.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_enable <= 1'b0;
      r_loop   <= 1'b0;
      r_irq_en <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_start <= w_wr && (w_off == OffCtrl) && wb.wbs_sel_i[0] && wb.wbs_dat_i[2];
      if (w_wr && (w_off == OffCtrl) && wb.wbs_sel_i[0]) begin
        r_enable <= wb.wbs_dat_i[0];
        r_loop   <= wb.wbs_dat_i[1];
        r_irq_en <= wb.wbs_dat_i[3];
      end
    end
  end

  // PERIOD and LAST registers with byte-lane writes.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_period <= PeriodRst;
      r_last   <= 4'hF;
    end else begin
      if (w_wr && (w_off == OffPeriod)) begin
        r_period <= f_lanes(r_period, wb.wbs_dat_i, wb.wbs_sel_i);
      end
      if (w_wr && (w_off == OffLast) && wb.wbs_sel_i[0]) begin
        r_last <= wb.wbs_dat_i[3:0];
      end
    end
  end

  // Sticky done flag (set beats W1C) and registered interrupt.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_done <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (seq_done_i) begin
        r_done <= 1'b1;
      end else if (w_wr && (w_off == OffStatus) && wb.wbs_sel_i[1] && wb.wbs_dat_i[8]) begin
        r_done <= 1'b0;
      end
      r_irq <= r_done & r_irq_en;
    end
  end

  // Sequence memory; the sequencer port sees the pre-write value on a same-edge hit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < int'(SEQ_DEPTH); i++) r_seq[i] <= '0;
      r_seq_rd <= '0;
    end else begin
      if (w_wr && w_seq_sel) begin
        r_seq[w_seq_idx] <= f_lanes(r_seq[w_seq_idx], wb.wbs_dat_i, wb.wbs_sel_i);
      end
      r_seq_rd <= (32'(seq_rd_addr_i) < SEQ_DEPTH) ? r_seq[seq_rd_addr_i] : '0;
    end
  end

  assign wb.wbs_ack_o  = r_ack;
  assign wb.wbs_dat_o  = r_dat;
  assign ctrl_enable_o = r_enable;
  assign ctrl_loop_o   = r_loop;
  assign start_o       = r_start;
  assign step_period_o = r_period;
  assign seq_last_o    = r_last;
  assign seq_rd_data_o = r_seq_rd;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_wb_seq_regs.sv
// Scoreboard bench for wb_seq_regs: stimulus pushes expected acks/read data,
// a negedge monitor pops and compares whenever the DUT acks.
module tb_wb_seq_regs;

  localparam logic [31:0] AdrCtrl   = 32'h3000_0000;
  localparam logic [31:0] AdrStatus = 32'h3000_0004;
  localparam logic [31:0] AdrPeriod = 32'h3000_0008;
  localparam logic [31:0] AdrLast   = 32'h3000_000C;
  localparam logic [31:0] AdrId     = 32'h3000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  seq_rd_addr;
  logic        seq_busy;
  logic [3:0]  seq_index;
  logic        seq_done;
  logic        ctrl_enable;
  logic        ctrl_loop;
  logic        start;
  logic [31:0] period;
  logic [3:0]  last;
  logic [31:0] seq_rd_data;
  logic        irq;

  int n_chk   = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  typedef struct {
    bit          chk;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_seq_regs_if bus ();

  wb_seq_regs dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wb            (bus),
    .ctrl_enable_o (ctrl_enable),
    .ctrl_loop_o   (ctrl_loop),
    .start_o       (start),
    .step_period_o (period),
    .seq_last_o    (last),
    .seq_rd_addr_i (seq_rd_addr),
    .seq_rd_data_o (seq_rd_data),
    .seq_busy_i    (seq_busy),
    .seq_index_i   (seq_index),
    .seq_done_i    (seq_done),
    .irq_o         (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit chk, input logic [31:0] dat, input int cyc);
    exp_t e;
    e.chk = chk;
    e.dat = dat;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Drive a request starting just after a rising edge; the ack is due one edge later.
  task automatic bus_start(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit expect_ack, input bit chk,
                           input logic [31:0] exp);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    if (expect_ack) push_exp(chk, exp, cyc_cnt + 1);
  endtask

  task automatic bus_end();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_rd(input logic [31:0] adr, input logic [31:0] exp);
    bus_start(1'b0, adr, 32'd0, 4'hF, 1'b1, 1'b1, exp);
    @(posedge clk); #1;
    bus_end();
    @(posedge clk); #1;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus_start(1'b1, adr, dat, sel, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    bus_end();
    @(posedge clk); #1;
  endtask

  // Monitor: every ack must match the oldest expectation in time and data.
  always @(negedge clk) begin
    if (bus.wbs_ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc_cnt);
      end else begin
        mon_e = sb.pop_front();
        check("ack_cycle", cyc_cnt, mon_e.cyc);
        if (mon_e.chk) check("read_data", bus.wbs_dat_o, mon_e.dat);
      end
    end else begin
      check("dat_idle_zero", bus.wbs_dat_o, 32'd0);
    end
  end

  initial begin
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_dat_i = 32'd0;
    bus.wbs_adr_i = 32'd0;
    seq_rd_addr   = 4'd0;
    seq_busy      = 1'b0;
    seq_index     = 4'd0;
    seq_done      = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    check("rst_period", period, 32'd1000);
    check("rst_last", {28'd0, last}, 32'hF);
    check("rst_ctrl", {29'd0, irq, ctrl_loop, ctrl_enable}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_seq_rd", seq_rd_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ID and PERIOD byte lanes
    wb_rd(AdrId, 32'h4D4D_5301);
    wb_wr(AdrId, 32'h0, 4'hF);
    wb_rd(AdrId, 32'h4D4D_5301);
    wb_rd(AdrPeriod, 32'd1000);
    wb_wr(AdrPeriod, 32'hAABB_CCDD, 4'b0101);
    wb_rd(AdrPeriod, 32'h00BB_03DD);
    check("period_out", period, 32'h00BB_03DD);

    // LAST, including an all-lanes-off write
    wb_rd(AdrLast, 32'hF);
    wb_wr(AdrLast, 32'h3, 4'b0001);
    check("last_out", {28'd0, last}, 32'h3);
    wb_wr(AdrLast, 32'hA, 4'b0000);
    wb_rd(AdrLast, 32'h3);

    // Unmapped in-window offset
    wb_wr(32'h3000_0020, 32'hFFFF_FFFF, 4'hF);
    wb_rd(32'h3000_0020, 32'd0);

    // SEQ[5] write with a same-edge sequencer read of entry 5
    seq_rd_addr = 4'd5;
    @(posedge clk); #1;
    bus_start(1'b1, 32'h3000_0054, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    check("seq_rd_old", seq_rd_data, 32'd0);
    bus_end();
    @(posedge clk); #1;
    check("seq_rd_new", seq_rd_data, 32'h1234_5678);
    wb_rd(32'h3000_0054, 32'h1234_5678);
    wb_wr(32'h3000_007C, 32'hFFFF_FFFF, 4'b1000);
    wb_rd(32'h3000_007C, 32'hFF00_0000);
    seq_rd_addr = 4'd15;
    @(posedge clk); #1;
    check("seq_rd_15", seq_rd_data, 32'hFF00_0000);

    // CTRL with start pulse; start needs lane 0
    bus_start(1'b1, AdrCtrl, 32'h4, 4'b0010, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    check("start_no_lane0", {31'd0, start}, 32'd0);
    bus_end();
    @(posedge clk); #1;
    bus_start(1'b1, AdrCtrl, 32'hF, 4'b0001, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    check("start_pulse", {31'd0, start}, 32'd1);
    check("ctrl_outs", {30'd0, ctrl_loop, ctrl_enable}, 32'h3);
    bus_end();
    @(posedge clk); #1;
    check("start_clear", {31'd0, start}, 32'd0);
    wb_rd(AdrCtrl, 32'hB);

    // done_sticky and irq
    seq_done = 1'b1;
    @(posedge clk); #1;
    seq_done = 1'b0;
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_set", {31'd0, irq}, 32'd1);
    wb_rd(AdrStatus, 32'h100);
    bus_start(1'b1, AdrStatus, 32'h100, 4'b0010, 1'b1, 1'b0, 32'd0);
    seq_done = 1'b1;
    @(posedge clk); #1;
    seq_done = 1'b0;
    bus_end();
    @(posedge clk); #1;
    wb_rd(AdrStatus, 32'h100);
    check("irq_kept", {31'd0, irq}, 32'd1);
    bus_start(1'b1, AdrStatus, 32'h100, 4'b0010, 1'b1, 1'b0, 32'd0);
    @(posedge clk); #1;
    check("irq_w1c_lag", {31'd0, irq}, 32'd1);
    bus_end();
    @(posedge clk); #1;
    check("irq_w1c", {31'd0, irq}, 32'd0);
    wb_rd(AdrStatus, 32'h0);

    // Held strobe for 6 cycles: acks on cycles 1, 3, 5
    seq_busy  = 1'b1;
    seq_index = 4'hA;
    begin
      int c;
      c = cyc_cnt;
      bus_start(1'b0, AdrStatus, 32'd0, 4'hF, 1'b0, 1'b0, 32'd0);
      push_exp(1'b1, 32'hA1, c + 1);
      push_exp(1'b1, 32'hA1, c + 3);
      push_exp(1'b1, 32'hA1, c + 5);
      repeat (5) @(posedge clk);
      #1;
      bus_end();
      @(posedge clk); #1;
    end
    seq_busy  = 1'b0;
    seq_index = 4'h0;

    // Out-of-window: never acked, no state change
    bus_start(1'b0, 32'h3001_0000, 32'd0, 4'hF, 1'b0, 1'b0, 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check("oow_noack", {31'd0, bus.wbs_ack_o}, 32'd0);
    end
    bus_end();
    bus_start(1'b1, 32'h3001_0008, 32'd0, 4'hF, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    bus_end();
    @(posedge clk); #1;
    wb_rd(AdrPeriod, 32'h00BB_03DD);

    // Reset during the request cycle of a PERIOD write
    bus_start(1'b1, AdrPeriod, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    check("rst_mid_period", period, 32'd1000);
    check("rst_mid_enable", {31'd0, ctrl_enable}, 32'd0);
    bus_end();
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    wb_rd(AdrPeriod, 32'd1000);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_seq_regs.md
Name: wb_seq_regs

Overview:
- Wishbone classic slave (responder) that gives the management SoC's Wishbone initiator access to the motor sequencer.
- Holds the control, status, step-period and last-index registers, plus a 16-entry sequence memory.
- The sequencer core reads the sequence memory through a private, registered read port.
- Sits in user_project_wrapper between the wbs_* pins and the sequencer core; it drives wbs_ack_o and wbs_dat_o.

Parameters:
- BASE_ADDR, 32'h3000_0000, window base address.
- ADDR_MASK, 32'hFFFF_0000, bits compared against BASE_ADDR for window hit.
- SEQ_DEPTH, 16, number of sequence entries; must be a power of 2, at most 16.
- ID_VALUE, 32'h4D4D_5301, value of the read-only ID register.

Ports:
- wb_clk_i  in  1  sole clock; all logic is on the rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  bus cycle.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte lane enables.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data; valid only while wbs_ack_o = 1.
- ctrl_enable_o  out  1  CTRL bit0.
- ctrl_loop_o  out  1  CTRL bit1.
- start_o  out  1  one-cycle start pulse.
- step_period_o  out  32  PERIOD register.
- seq_last_o  out  4  LAST register.
- seq_rd_addr_i  in  4  sequencer read index.
- seq_rd_data_o  out  32  sequence entry; 1-cycle latency.
- seq_busy_i  in  1  sequencer running.
- seq_index_i  in  4  current step index.
- seq_done_i  in  1  sequence-complete pulse.
- irq_o  out  1  interrupt request.

Behaviour:
- Request: req = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR) & !ack_q.
- Response timing:
  - The edge that samples req sets ack_q; wbs_ack_o = ack_q, so the ack is high for exactly one cycle.
  - If stb is still held during the ack cycle, that cycle is not a request. A held stb is re-accepted on the following edge, giving at most one transfer every 2 cycles.
- Out-of-window addresses are never acked and change no state.
- Decode uses wbs_adr_i[7:2]. Offsets:
  - 0x00 CTRL: bit0 enable, bit1 loop, bit2 start (write-only; reads 0), bit3 irq_en. Reset 0.
  - 0x04 STATUS (read-only except bit8): bit0 = seq_busy_i, bits7:4 = seq_index_i, bit8 = done_sticky (write 1 to clear).
  - 0x08 PERIOD: reset 32'd1000.
  - 0x0C LAST: bits3:0, reset 4'hF.
  - 0x10 ID: read-only, returns ID_VALUE.
  - 0x40-0x7C SEQ[0..15]: entry = adr[5:2]; reset 0.
- Unmapped offsets inside the window are acked, read 0, and ignore writes. Unused register bits read 0.
- Writes commit on the same edge that sets ack_q. Each byte lane n is written only when wbs_sel_i[n] = 1. This applies to all writable registers and SEQ entries.
- Reads: wbs_dat_o is registered on the request edge. It is 0 whenever ack_q = 0.
- start_o pulses high for one cycle, on the cycle after the commit edge of a CTRL write with sel[0]=1 and dat[2]=1. This happens even if seq_busy_i = 1.
- done_sticky:
  - set by seq_done_i;
  - cleared by a STATUS write with sel[1]=1 and dat[8]=1;
  - set wins when set and clear occur in the same cycle.
- irq_o = done_sticky & irq_en, registered, so it lags done_sticky by 1 cycle.
- Sequencer read port: seq_rd_data_o <= SEQ[seq_rd_addr_i] every cycle. If a WB write hits the same entry on the same edge, the port returns the old value; the new value appears one cycle later.
- Reset, asynchronous, at any time including mid-transaction:
  - ack_q, wbs_dat_o, start_o, irq_o, done_sticky, CTRL, SEQ and seq_rd_data_o go to 0 immediately;
  - PERIOD goes to 1000 and LAST to 4'hF;
  - any in-flight transfer is dropped with no ack;
  - the first request after release is acked normally.

Test Plan:
- Read ID at 0x3000_0010 -> ack exactly 1 cycle after the request; wbs_dat_o = 32'h4D4D_5301 during the ack; 0 otherwise.
- Write PERIOD = 0xAABBCCDD with sel = 4'b0101, after reset -> readback 0x00BB03DD (reset value 1000 = 0x3E8); step_period_o matches.
- Write SEQ[5] = 0x12345678 while seq_rd_addr_i = 5 on the same edge -> seq_rd_data_o = 0 for 1 cycle, then 0x12345678.
- Pulse seq_done_i; set irq_en -> done_sticky = 1 and irq_o = 1. W1C STATUS in the same cycle as a second seq_done_i -> bit8 stays 1. W1C alone -> irq_o = 0 one cycle later.
- Hold stb/cyc for 6 cycles reading 0x3000_0004 -> acks on cycles 1, 3 and 5 only. Address 0x3001_0000 -> no ack ever.
- Assert wb_rst_i during the request cycle of a PERIOD write -> no ack, PERIOD = 1000. The next read after release is acked and returns 1000.
